parking_lot_ctrl: RTL and testbench

//   Parametrised parking-lot controller: tracks NUM_SLOTS slot occupancy, allocates the

---
 rtl/parking_lot_ctrl.sv | 158 +++++++++++++++
 tb/tb_parking_lot_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/parking_lot_ctrl.sv
// Parking-lot controller: slot occupancy, lowest-free-slot allocation on entry,
// addressed release on exit, timed door with one-deep pending event per gate.
module parking_lot_ctrl #(
   parameter int NUM_SLOTS   = 8,
   parameter int IDX_W       = 3,
   parameter int CNT_W       = 4,
   parameter int DOOR_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 entry_sensor,
   input  logic                 exit_sensor,
   input  logic [IDX_W-1:0]     exit_slot,
   output logic [NUM_SLOTS-1:0] parking_slots,
   output logic                 door_open_light,
   output logic                 full_light,
   output logic [CNT_W-1:0]     capacity,
   output logic [IDX_W-1:0]     best_place,
   output logic                 entry_reject,
   output logic                 exit_error
);

   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] ENTRY_OPEN = 2'd1;
   localparam logic [1:0] EXIT_OPEN  = 2'd2;

   localparam int               HOLD_W    = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DOOR_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CAP_FULL  = CNT_W'(NUM_SLOTS);

   // One-hot decode; indices at or beyond NUM_SLOTS yield an all-zero mask.
   function automatic logic [NUM_SLOTS-1:0] slot_mask(input logic [IDX_W-1:0] idx);
      logic [NUM_SLOTS-1:0] m;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         m[i] = (32'(idx) == i);
      end
      return m;
   endfunction

   logic [1:0]           state_r;
   logic [HOLD_W-1:0]    hold_cnt_r;
   logic [NUM_SLOTS-1:0] slots_r;
   logic [CNT_W-1:0]     capacity_r;
   logic                 door_r;
   logic                 entry_reject_r;
   logic                 exit_error_r;
   logic                 entry_prev_r;
   logic                 exit_prev_r;
   logic                 entry_pend_r;
   logic                 exit_pend_r;
   logic [IDX_W-1:0]     exit_slot_pend_r;

   logic                 entry_evt_s;
   logic                 exit_evt_s;
   logic                 entry_req_s;
   logic                 exit_req_s;
   logic [IDX_W-1:0]     exit_idx_s;
   logic                 exit_ok_s;
   logic [IDX_W-1:0]     best_place_s;

   // Lowest free slot; scanning downward lets the lowest index win, 0 when full.
   always_comb begin
      best_place_s = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         best_place_s = slots_r[i] ? best_place_s : IDX_W'(i);
      end
   end

   // New sensor edges merged with pending requests for the IDLE decision.
   always_comb begin
      entry_evt_s = entry_sensor & ~entry_prev_r;
      exit_evt_s  = exit_sensor & ~exit_prev_r;
      entry_req_s = entry_pend_r | entry_evt_s;
      exit_req_s  = exit_pend_r | exit_evt_s;
      exit_idx_s  = exit_pend_r ? exit_slot_pend_r : exit_slot;
      exit_ok_s   = (32'(exit_idx_s) < NUM_SLOTS) &&
                    ((slots_r & slot_mask(exit_idx_s)) != '0);
   end

   // Main controller: edge registers, pending capture, FSM, occupancy and door.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r          <= IDLE;
         hold_cnt_r       <= '0;
         slots_r          <= '0;
         capacity_r       <= CAP_FULL;
         door_r           <= 1'b0;
         entry_reject_r   <= 1'b0;
         exit_error_r     <= 1'b0;
         entry_prev_r     <= 1'b0;
         exit_prev_r      <= 1'b0;
         entry_pend_r     <= 1'b0;
         exit_pend_r      <= 1'b0;
         exit_slot_pend_r <= '0;
      end else begin
         entry_prev_r   <= entry_sensor;
         exit_prev_r    <= exit_sensor;
         entry_reject_r <= 1'b0;
         exit_error_r   <= 1'b0;
         if (entry_evt_s) begin
            entry_pend_r <= 1'b1;
         end
         // A repeat exit while one is pending is dropped, keeping the first slot.
         if (exit_evt_s && !exit_pend_r) begin
            exit_pend_r      <= 1'b1;
            exit_slot_pend_r <= exit_slot;
         end
         case (state_r)
            IDLE: begin
               if (exit_req_s) begin
                  exit_pend_r <= 1'b0;
                  if (exit_ok_s) begin
                     slots_r    <= slots_r & ~slot_mask(exit_idx_s);
                     capacity_r <= capacity_r + CNT_W'(1);
                     door_r     <= 1'b1;
                     hold_cnt_r <= '0;
                     state_r    <= EXIT_OPEN;
                  end else begin
                     exit_error_r <= 1'b1;
                  end
               end else if (entry_req_s) begin
                  entry_pend_r <= 1'b0;
                  if (capacity_r != '0) begin
                     slots_r    <= slots_r | slot_mask(best_place_s);
                     capacity_r <= capacity_r - CNT_W'(1);
                     door_r     <= 1'b1;
                     hold_cnt_r <= '0;
                     state_r    <= ENTRY_OPEN;
                  end else begin
                     entry_reject_r <= 1'b1;
                  end
               end
            end
            ENTRY_OPEN, EXIT_OPEN: begin
               if (hold_cnt_r == HOLD_LAST) begin
                  door_r  <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
               end
            end
            default: begin
               door_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign parking_slots   = slots_r;
   assign capacity        = capacity_r;
   assign door_open_light = door_r;
   assign entry_reject    = entry_reject_r;
   assign exit_error      = exit_error_r;
   assign best_place      = best_place_s;
   assign full_light      = (capacity_r == '0);

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed bench for parking_lot_ctrl: vector table of single gate events plus
// hand sequences for simultaneous entry/exit and reset during door-open.
module tb_parking_lot_ctrl;

   localparam int NS = 8;
   localparam int DC = 4;
   localparam int NV = 15;

   logic       clk;
   logic       rst;
   logic       entry_sensor;
   logic       exit_sensor;
   logic [2:0] exit_slot;
   logic [7:0] parking_slots;
   logic       door_open_light;
   logic       full_light;
   logic [3:0] capacity;
   logic [2:0] best_place;
   logic       entry_reject;
   logic       exit_error;

   int total;
   int bad;

   typedef struct {
      logic       ent;
      logic       ext;
      logic [2:0] slot;
      logic [7:0] exp_slots;
      logic [3:0] exp_cap;
      logic [2:0] exp_best;
      logic       exp_door;
      logic       exp_rej;
      logic       exp_err;
   } vec_t;

   vec_t vecs [NV];

   parking_lot_ctrl #(
      .NUM_SLOTS(NS), .IDX_W(3), .CNT_W(4), .DOOR_CYCLES(DC)
   ) dut (
      .clk(clk), .rst(rst),
      .entry_sensor(entry_sensor), .exit_sensor(exit_sensor), .exit_slot(exit_slot),
      .parking_slots(parking_slots), .door_open_light(door_open_light),
      .full_light(full_light), .capacity(capacity), .best_place(best_place),
      .entry_reject(entry_reject), .exit_error(exit_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic [7:0] s, input logic [3:0] c,
                            input logic [2:0] b, input logic d);
      chk({tag, " slots"}, 32'(parking_slots), 32'(s));
      chk({tag, " cap"},   32'(capacity), 32'(c));
      chk({tag, " best"},  32'(best_place), 32'(b));
      chk({tag, " full"},  32'(full_light), 32'(c == 4'd0));
      chk({tag, " door"},  32'(door_open_light), 32'(d));
   endtask

   // Door has already risen; expect DC-1 more high cycles then a low one.
   task automatic chk_door_hold(input string tag);
      for (int k = 1; k < DC; k++) begin
         step();
         chk($sformatf("%s door_hi%0d", tag, k), 32'(door_open_light), 32'd1);
      end
      step();
      chk({tag, " door_close"}, 32'(door_open_light), 32'd0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      vecs[0]  = '{1'b1, 1'b0, 3'd0, 8'h01, 4'd7, 3'd1, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 3'd0, 8'h03, 4'd6, 3'd2, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 3'd0, 8'h07, 4'd5, 3'd3, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 3'd0, 8'h0F, 4'd4, 3'd4, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 3'd1, 8'h0D, 4'd5, 3'd1, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 3'd0, 8'h0F, 4'd4, 3'd4, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 3'd6, 8'h0F, 4'd4, 3'd4, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 3'd7, 8'h0F, 4'd4, 3'd4, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 1'b0, 3'd0, 8'h1F, 4'd3, 3'd5, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 3'd0, 8'h3F, 4'd2, 3'd6, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 3'd0, 8'h7F, 4'd1, 3'd7, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 3'd0, 8'hFF, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 3'd0, 8'hFF, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 3'd5, 8'hDF, 4'd1, 3'd5, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 3'd0, 8'hFF, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0};

      rst          = 1'b1;
      entry_sensor = 1'b0;
      exit_sensor  = 1'b0;
      exit_slot    = 3'd0;
      step();
      step();
      chk_state("reset", 8'h00, 4'd8, 3'd0, 1'b0);
      chk("reset rej", 32'(entry_reject), 32'd0);
      chk("reset err", 32'(exit_error), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step();
      step();

      for (int i = 0; i < NV; i++) begin
         entry_sensor = vecs[i].ent;
         exit_sensor  = vecs[i].ext;
         exit_slot    = vecs[i].slot;
         step();
         chk_state($sformatf("v%0d", i), vecs[i].exp_slots, vecs[i].exp_cap,
                   vecs[i].exp_best, vecs[i].exp_door);
         chk($sformatf("v%0d rej", i), 32'(entry_reject), 32'(vecs[i].exp_rej));
         chk($sformatf("v%0d err", i), 32'(exit_error), 32'(vecs[i].exp_err));
         entry_sensor = 1'b0;
         exit_sensor  = 1'b0;
         if (vecs[i].exp_door) begin
            chk_door_hold($sformatf("v%0d", i));
         end else begin
            step();
            chk($sformatf("v%0d rej_clr", i), 32'(entry_reject), 32'd0);
            chk($sformatf("v%0d err_clr", i), 32'(exit_error), 32'd0);
            chk($sformatf("v%0d door_low", i), 32'(door_open_light), 32'd0);
         end
         step();
         step();
      end

      // Simultaneous entry and exit while full: exit first, entry after one idle cycle.
      entry_sensor = 1'b1;
      exit_sensor  = 1'b1;
      exit_slot    = 3'd5;
      step();
      chk_state("sim exit", 8'hDF, 4'd1, 3'd5, 1'b1);
      chk("sim rej0", 32'(entry_reject), 32'd0);
      entry_sensor = 1'b0;
      exit_sensor  = 1'b0;
      chk_door_hold("sim exit");
      chk_state("sim gap", 8'hDF, 4'd1, 3'd5, 1'b0);
      step();
      chk_state("sim entry", 8'hFF, 4'd0, 3'd0, 1'b1);
      chk("sim rej1", 32'(entry_reject), 32'd0);
      chk_door_hold("sim entry");
      step();

      // Reset during ENTRY_OPEN with an entry pending.
      exit_sensor = 1'b1;
      exit_slot   = 3'd0;
      step();
      chk_state("rs exit", 8'hFE, 4'd1, 3'd0, 1'b1);
      exit_sensor = 1'b0;
      chk_door_hold("rs exit");
      step();
      entry_sensor = 1'b1;
      step();
      chk_state("rs entry", 8'hFF, 4'd0, 3'd0, 1'b1);
      entry_sensor = 1'b0;
      step();
      chk("rs open1", 32'(door_open_light), 32'd1);
      entry_sensor = 1'b1;
      step();
      chk("rs open2", 32'(door_open_light), 32'd1);
      rst          = 1'b1;
      entry_sensor = 1'b0;
      #1;
      chk_state("rs async", 8'h00, 4'd8, 3'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         chk($sformatf("rs idle%0d door", k), 32'(door_open_light), 32'd0);
      end
      chk_state("rs after", 8'h00, 4'd8, 3'd0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
